// File: rtl/fetch_inflight_buffer_pkg.sv
// Shared definitions for the fetch in-flight buffer.
//   - Default geometry (depth, address and instruction widths).
//   - Bit layout of a packed entry {filled, addr, data}, data in the low bits.
//   - Classification of an i-cache response in a given cycle.
package fetch_inflight_buffer_pkg;

    localparam int unsigned FETCH_DEPTH        = 2;
    localparam int unsigned FETCH_ADDRESS_BITS = 12;
    localparam int unsigned FETCH_DATA_WIDTH   = 32;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_DROP,      // owed by a redirect, discarded silently
        RESP_FILL,      // completes the oldest unfilled entry
        RESP_SPURIOUS   // nothing outstanding
    } resp_action_e;

    function automatic int unsigned entry_width(input int unsigned aw, input int unsigned dw);
        return 1 + aw + dw;
    endfunction

    function automatic int unsigned entry_addr_lsb(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned entry_filled_bit(input int unsigned aw, input int unsigned dw);
        return aw + dw;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_inflight_buffer_wrap_ptr.sv
// Modulo-DEPTH pointer with synchronous clear and increment.
//   clock  rising-edge clock
//   reset  asynchronous active-low reset (pointer -> 0)
//   clear  synchronous clear, takes priority over inc
//   inc    advance by one, wrapping DEPTH-1 -> 0
//   ptr    current pointer value
// The wrap uses an explicit compare so DEPTH need not be a power of two.
module fetch_inflight_buffer_wrap_ptr
    import fetch_inflight_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        inc,
    output logic [ptr_width(DEPTH)-1:0] ptr
);

    localparam int unsigned PW = ptr_width(DEPTH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/fetch_inflight_buffer.sv
// Fetch in-flight buffer: issues PC fetches to the i-cache, bounds outstanding
// requests to DEPTH, checks in-order responses against issued PCs and holds
// returned instructions until decode takes them. A redirect (flush) discards
// everything and remembers how many responses the cache still owes.
//   clock, reset                 rising-edge clock, async active-low reset
//   req_valid/req_addr/req_ready fetch request handshake
//   icache_read/icache_addr      read strobe and address to the i-cache
//   icache_valid/_resp_addr/_data  i-cache response
//   flush                        redirect
//   out_valid/out_pc/out_instruction/out_ready  decode handshake
//   inflight_count               allocated entries plus responses still to drop
//   err_order, err_spurious      sticky protocol error flags
module fetch_inflight_buffer
    import fetch_inflight_buffer_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = FETCH_ADDRESS_BITS,
    parameter int unsigned DATA_WIDTH   = FETCH_DATA_WIDTH,
    parameter int unsigned DEPTH        = FETCH_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req_valid,
    input  logic [ADDRESS_BITS-1:0]      req_addr,
    output logic                         req_ready,
    output logic                         icache_read,
    output logic [ADDRESS_BITS-1:0]      icache_addr,
    input  logic                         icache_valid,
    input  logic [ADDRESS_BITS-1:0]      icache_resp_addr,
    input  logic [DATA_WIDTH-1:0]        icache_data,
    input  logic                         flush,
    output logic                         out_valid,
    output logic [ADDRESS_BITS-1:0]      out_pc,
    output logic [DATA_WIDTH-1:0]        out_instruction,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   inflight_count,
    output logic                         err_order,
    output logic                         err_spurious
);

    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned PW    = ptr_width(DEPTH);
    localparam int unsigned EW    = entry_width(ADDRESS_BITS, DATA_WIDTH);
    localparam int unsigned A_LSB = entry_addr_lsb(DATA_WIDTH);
    localparam int unsigned F_BIT = entry_filled_bit(ADDRESS_BITS, DATA_WIDTH);

    logic [EW-1:0]     entry_q [DEPTH];
    logic [CW-1:0]     count_q, drop_q;
    logic              err_order_q, err_spurious_q;
    logic [PW-1:0]     alloc_ptr, fill_ptr, pop_ptr;

    logic [DEPTH-1:0]  filled_vec;
    logic [CW-1:0]     filled_cnt, unfilled;
    logic [CW:0]       occupancy, owed_sum;
    logic [CW-1:0]     flush_drop;
    logic              accept, pop, do_fill;
    resp_action_e      resp;

    always_comb begin
        filled_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            filled_vec[i] = entry_q[i][F_BIT];
            filled_cnt    = filled_cnt + CW'(entry_q[i][F_BIT]);
        end
    end

    // Allocated-but-unfilled entries; popped entries have their filled bit cleared.
    assign unfilled  = count_q - filled_cnt;
    assign occupancy = {1'b0, count_q} + {1'b0, drop_q};

    // reset gating keeps every output at zero while reset is held.
    assign req_ready   = reset & ~flush & (occupancy < (CW+1)'(DEPTH));
    assign accept      = req_valid & req_ready;
    assign icache_read = accept;
    assign icache_addr = reset ? req_addr : '0;

    assign out_valid       = filled_vec[pop_ptr];
    assign out_pc          = entry_q[pop_ptr][A_LSB +: ADDRESS_BITS];
    assign out_instruction = entry_q[pop_ptr][DATA_WIDTH-1:0];
    assign pop             = out_valid & out_ready & ~flush;

    assign inflight_count = CW'(occupancy);
    assign err_order      = err_order_q;
    assign err_spurious   = err_spurious_q;

    always_comb begin
        resp = RESP_NONE;
        if (icache_valid) begin
            if (drop_q != '0)        resp = RESP_DROP;
            else if (unfilled != '0) resp = RESP_FILL;
            else                     resp = RESP_SPURIOUS;
        end
    end

    assign do_fill = (resp == RESP_FILL) & ~flush;

    // Responses owed after a redirect: prior drops plus unfilled entries, less
    // the response (if any) consumed in the flush cycle itself.
    assign owed_sum   = {1'b0, drop_q} + {1'b0, unfilled};
    assign flush_drop = (icache_valid && owed_sum != '0) ? CW'(owed_sum - (CW+1)'(1))
                                                         : CW'(owed_sum);

    fetch_inflight_buffer_wrap_ptr #(.DEPTH(DEPTH)) u_alloc_ptr (
        .clock (clock), .reset (reset), .clear (flush), .inc (accept),  .ptr (alloc_ptr)
    );
    fetch_inflight_buffer_wrap_ptr #(.DEPTH(DEPTH)) u_fill_ptr (
        .clock (clock), .reset (reset), .clear (flush), .inc (do_fill), .ptr (fill_ptr)
    );
    fetch_inflight_buffer_wrap_ptr #(.DEPTH(DEPTH)) u_pop_ptr (
        .clock (clock), .reset (reset), .clear (flush), .inc (pop),     .ptr (pop_ptr)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            count_q        <= '0;
            drop_q         <= '0;
            err_order_q    <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            if (flush) begin
                for (int unsigned i = 0; i < DEPTH; i++) entry_q[i][F_BIT] <= 1'b0;
                count_q <= '0;
                drop_q  <= flush_drop;
            end else begin
                // pop, alloc and fill always target distinct entries.
                if (pop) entry_q[pop_ptr][F_BIT] <= 1'b0;
                if (accept) begin
                    entry_q[alloc_ptr][A_LSB +: ADDRESS_BITS] <= req_addr;
                    entry_q[alloc_ptr][F_BIT]                 <= 1'b0;
                end
                if (do_fill) begin
                    entry_q[fill_ptr][DATA_WIDTH-1:0] <= icache_data;
                    entry_q[fill_ptr][F_BIT]          <= 1'b1;
                    if (icache_resp_addr != entry_q[fill_ptr][A_LSB +: ADDRESS_BITS])
                        err_order_q <= 1'b1;
                end
                count_q <= count_q + CW'(accept) - CW'(pop);
                if (resp == RESP_DROP) drop_q <= drop_q - CW'(1);
            end
            if (resp == RESP_SPURIOUS) err_spurious_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_inflight_buffer.sv
module tb_fetch_inflight_buffer;

    localparam int AB    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, icache_read, icache_valid, flush;
    logic [AB-1:0] req_addr, icache_addr, icache_resp_addr, out_pc;
    logic [DW-1:0] icache_data, out_instruction;
    logic          out_valid, out_ready, err_order, err_spurious;
    logic [CW-1:0] inflight_count;

    fetch_inflight_buffer #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_ready        (req_ready),
        .icache_read      (icache_read),
        .icache_addr      (icache_addr),
        .icache_valid     (icache_valid),
        .icache_resp_addr (icache_resp_addr),
        .icache_data      (icache_data),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_pc           (out_pc),
        .out_instruction  (out_instruction),
        .out_ready        (out_ready),
        .inflight_count   (inflight_count),
        .err_order        (err_order),
        .err_spurious     (err_spurious)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: FIFO of issued-but-unanswered PCs, FIFO of answered
    // instructions waiting for decode, count of responses owed after redirects.
    typedef struct packed {
        logic [AB-1:0] a;
        logic [DW-1:0] d;
    } item_t;

    logic [AB-1:0] unf_q[$];
    item_t         rdy_q[$];
    int            m_drop;
    logic          m_eo, m_es;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        unf_q.delete();
        rdy_q.delete();
        m_drop = 0;
        m_eo   = 1'b0;
        m_es   = 1'b0;
    endtask

    function automatic logic exp_ready();
        return !flush && (unf_q.size() + rdy_q.size() + m_drop < DEPTH);
    endfunction

    task automatic check_outputs();
        int   cnt = unf_q.size() + rdy_q.size();
        logic rdy = exp_ready();
        chk("req_ready",      req_ready,      rdy);
        chk("icache_read",    icache_read,    req_valid && rdy);
        chk("icache_addr",    icache_addr,    req_addr);
        chk("out_valid",      out_valid,      rdy_q.size() > 0);
        if (rdy_q.size() > 0) begin
            chk("out_pc",          out_pc,          rdy_q[0].a);
            chk("out_instruction", out_instruction, rdy_q[0].d);
        end
        chk("inflight_count", inflight_count, 64'(cnt + m_drop));
        chk("err_order",      err_order,      m_eo);
        chk("err_spurious",   err_spurious,   m_es);
    endtask

    task automatic model_update();
        logic          acc  = req_valid && exp_ready();
        logic          popn = (rdy_q.size() > 0) && out_ready && !flush;
        logic [AB-1:0] a;
        if (flush) begin
            if (icache_valid) begin
                if (m_drop > 0)             m_drop--;
                else if (unf_q.size() > 0)  void'(unf_q.pop_front());
                else                        m_es = 1'b1;
            end
            m_drop += unf_q.size();
            unf_q.delete();
            rdy_q.delete();
        end else begin
            if (popn) void'(rdy_q.pop_front());
            if (icache_valid) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else if (unf_q.size() > 0) begin
                    a = unf_q.pop_front();
                    if (icache_resp_addr !== a) m_eo = 1'b1;
                    rdy_q.push_back({a, icache_data});
                end else begin
                    m_es = 1'b1;
                end
            end
            if (acc) unf_q.push_back(req_addr);
        end
    endtask

    // Inputs are set at a falling edge; outputs are checked 1 time unit later.
    task automatic step();
        #1;
        check_outputs();
        model_update();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        req_valid        = 1'b0;
        req_addr         = '0;
        icache_valid     = 1'b0;
        icache_resp_addr = '0;
        icache_data      = '0;
        flush            = 1'b0;
        out_ready        = 1'b0;
    endtask

    task automatic request(input logic [AB-1:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
    endtask

    task automatic respond(input logic [AB-1:0] a, input logic [DW-1:0] d);
        icache_valid     = 1'b1;
        icache_resp_addr = a;
        icache_data      = d;
        step();
        icache_valid     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        model_reset();

        // Reset held with a request pending: everything reads zero.
        reset     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 12'h123;
        repeat (3) begin
            @(negedge clock);
            #1;
            chk("rst_req_ready",    req_ready,      0);
            chk("rst_icache_read",  icache_read,    0);
            chk("rst_icache_addr",  icache_addr,    0);
            chk("rst_out_valid",    out_valid,      0);
            chk("rst_inflight",     inflight_count, 0);
            chk("rst_err_order",    err_order,      0);
            chk("rst_err_spurious", err_spurious,   0);
        end
        reset = 1'b1;
        idle();
        #1;
        chk("post_rst_req_ready", req_ready,      1);
        chk("post_rst_inflight",  inflight_count, 0);
        step();

        // In-order pair, one-cycle response latency, no bypass.
        request(12'h000);
        request(12'h004);
        icache_valid = 1'b1; icache_resp_addr = 12'h000; icache_data = 32'h0000_0013;
        #1 chk("t2_no_bypass", out_valid, 0);
        step();
        icache_resp_addr = 12'h004; icache_data = 32'h0010_0093;
        #1;
        chk("t2_valid_after_1", out_valid, 1);
        chk("t2_pc0",           out_pc,    12'h000);
        step();
        icache_valid = 1'b0;
        out_ready    = 1'b1;
        step();
        #1;
        chk("t2_pc1",   out_pc,          12'h004);
        chk("t2_inst1", out_instruction, 32'h0010_0093);
        step();
        out_ready = 1'b0;
        #1 chk("t2_drained", out_valid, 0);
        step();

        // Full buffer: no accept on the pop cycle, accept on the following one.
        request(12'h020);
        request(12'h024);
        req_valid = 1'b1; req_addr = 12'h028;
        #1 chk("t3_full", req_ready, 0);
        step();
        respond(12'h020, 32'hAAAA_0001);
        req_valid = 1'b1;
        respond(12'h024, 32'hAAAA_0002);
        req_valid = 1'b1;
        step();
        out_ready = 1'b1;
        #1 chk("t3_pop_cycle_no_accept", req_ready, 0);
        step();
        #1 chk("t3_accept_after_pop", req_ready, 1);
        step();
        req_valid = 1'b0;
        #1 chk("t3_accept_plus_pop_count", inflight_count, 1);
        respond(12'h028, 32'hAAAA_0003);
        step();
        out_ready = 1'b0;
        step();

        // Flush before any response: both late responses are dropped.
        request(12'h010);
        request(12'h014);
        flush = 1'b1; req_valid = 1'b1; req_addr = 12'h018;
        #1 chk("t4_flush_ready", req_ready, 0);
        step();
        idle();
        #1 chk("t4_drop2", inflight_count, 2);
        respond(12'h010, 32'h1111_1111);
        respond(12'h014, 32'h2222_2222);
        #1;
        chk("t4_drop0",      inflight_count, 0);
        chk("t4_no_out",     out_valid,      0);
        chk("t4_no_err",     {err_order, err_spurious}, 0);
        step();

        // Flush coincident with the first response.
        request(12'h010);
        request(12'h014);
        flush = 1'b1;
        respond(12'h010, 32'h3333_3333);
        flush = 1'b0;
        #1 chk("t5_drop1", inflight_count, 1);
        req_valid = 1'b1; req_addr = 12'h100;
        respond(12'h014, 32'h4444_4444);
        req_valid = 1'b0;
        respond(12'h100, 32'h0000_0513);
        #1;
        chk("t5_pc",   out_pc,          12'h100);
        chk("t5_inst", out_instruction, 32'h0000_0513);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();

        // Randomized traffic with well-formed responses and occasional redirects.
        for (int n = 0; n < 400; n++) begin
            int owed = unf_q.size() + m_drop;
            req_valid        = 1'($urandom_range(0, 1));
            req_addr         = AB'($urandom_range(0, 1023) * 4);
            flush            = ($urandom_range(0, 19) == 0);
            out_ready        = ($urandom_range(0, 9) < 6);
            icache_valid     = (owed > 0) && ($urandom_range(0, 1) == 1);
            icache_resp_addr = (m_drop > 0) ? AB'($urandom) :
                               (unf_q.size() > 0 ? unf_q[0] : '0);
            icache_data      = $urandom;
            step();
        end
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < DEPTH + 2 && m_drop > 0; k++) respond(12'h0FC, 32'h0);
        #1 chk("rand_drained", inflight_count, 0);
        step();

        // Wrong response address, then a response with nothing outstanding.
        request(12'h000);
        request(12'h004);
        respond(12'h000, 32'h0000_0011);
        respond(12'h008, 32'h0000_0022);
        #1;
        chk("t6_err_order", err_order, 1);
        out_ready = 1'b1;
        step();
        #1;
        chk("t6_pc_delivered",   out_pc,          12'h004);
        chk("t6_data_delivered", out_instruction, 32'h0000_0022);
        step();
        out_ready = 1'b0;
        icache_valid = 1'b1; icache_resp_addr = 12'h0AC; icache_data = 32'h5;
        #1 chk("t6_spurious_before", err_spurious, 0);
        step();
        icache_valid = 1'b0;
        #1;
        chk("t6_spurious_sticky", err_spurious, 1);
        chk("t6_order_sticky",    err_order,    1);
        step();

        // Reset in the middle of a transaction clears state and errors.
        request(12'h200);
        reset = 1'b0;
        #1;
        chk("midrst_inflight",  inflight_count, 0);
        chk("midrst_err_order", err_order,      0);
        chk("midrst_req_ready", req_ready,      0);
        model_reset();
        reset = 1'b1;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
